// File: rtl/sprite_blitter.sv
// Draw engine feeding the 4-bpp framebuffer write port: full-frame CLEAR
// and clipped, transparent SPRITE copies from a sync-read sprite ROM.
module sprite_blitter #(
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int PIX_W       = 4,
    parameter int SPR_SIZE    = 16,
    parameter int SPR_COUNT   = 16,
    parameter int TRANSPARENT = 0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic                                         cmd_op,
    input  logic [$clog2(FB_W)-1:0]                      cmd_x,
    input  logic [$clog2(FB_H)-1:0]                      cmd_y,
    input  logic [$clog2(SPR_COUNT)-1:0]                 cmd_sprite,
    input  logic [PIX_W-1:0]                             cmd_color,
    output logic [$clog2(SPR_COUNT*SPR_SIZE*SPR_SIZE)-1:0] rom_addr,
    input  logic [PIX_W-1:0]                             rom_data,
    output logic                                         fb_we,
    output logic [$clog2(FB_W*FB_H)-1:0]                 fb_addr,
    output logic [PIX_W-1:0]                             fb_din,
    output logic                                         busy,
    output logic                                         done
);

    localparam int XW      = $clog2(FB_W);
    localparam int YW      = $clog2(FB_H);
    localparam int SPR_PIX = SPR_SIZE * SPR_SIZE;
    localparam int KW      = $clog2(SPR_PIX);
    localparam int CW      = $clog2(SPR_SIZE);
    localparam int RAW     = $clog2(SPR_COUNT * SPR_PIX);
    localparam int NPIX    = FB_W * FB_H;
    localparam int FAW     = $clog2(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fb_we_q, fb_we_d;
    logic [FAW-1:0]   fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0] fb_din_q, fb_din_d;
    logic [RAW-1:0]   rom_addr_q, rom_addr_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic             flush_q, flush_d;
    logic             p1_valid_q, p1_valid_d;
    logic [FAW-1:0]   p1_addr_q, p1_addr_d;

    logic [CW-1:0]    sx;
    logic [KW-CW-1:0] sy;
    logic [XW:0]      px;
    logic [YW:0]      py;
    logic             in_b;
    logic [FAW-1:0]   pix_addr;
    logic             wr_hit;

    // One extra bit on px/py so sprites hanging off the edge never wrap.
    always_comb begin
        sx       = k_q[CW-1:0];
        sy       = k_q[KW-1:CW];
        px       = (XW+1)'(x_q) + (XW+1)'(sx);
        py       = (YW+1)'(y_q) + (YW+1)'(sy);
        in_b     = (px < (XW+1)'(FB_W)) && (py < (YW+1)'(FB_H));
        pix_addr = FAW'(py) * FAW'(FB_W) + FAW'(px);
        wr_hit   = p1_valid_q && (rom_data != PIX_W'(TRANSPARENT));
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_din_d    = fb_din_q;
        rom_addr_d  = rom_addr_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        flush_d     = flush_q;
        p1_valid_d  = 1'b0;
        p1_addr_d   = p1_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    busy_d  = 1'b1;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    k_d     = '0;
                    flush_d = 1'b0;
                    if (cmd_op) begin
                        state_d   = S_CLEAR;
                        fb_we_d   = 1'b1;
                        fb_addr_d = '0;
                        fb_din_d  = cmd_color;
                    end else begin
                        state_d    = S_DRAW;
                        rom_addr_d = RAW'(cmd_sprite) * RAW'(SPR_PIX);
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (fb_addr_q == FAW'(NPIX - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = fb_addr_q + FAW'(1);
                end
            end
            S_DRAW: begin
                p1_valid_d = in_b;
                p1_addr_d  = pix_addr;
                fb_we_d    = wr_hit;
                fb_addr_d  = p1_addr_q;
                fb_din_d   = rom_data;
                if (k_q == KW'(SPR_PIX - 1)) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d        = k_q + KW'(1);
                    rom_addr_d = rom_addr_q + RAW'(1);
                end
            end
            S_FLUSH: begin
                fb_we_d   = wr_hit;
                fb_addr_d = p1_addr_q;
                fb_din_d  = rom_data;
                if (flush_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_din_q    <= '0;
            rom_addr_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            flush_q     <= 1'b0;
            p1_valid_q  <= 1'b0;
            p1_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_din_q    <= fb_din_d;
            rom_addr_q  <= rom_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            flush_q     <= flush_d;
            p1_valid_q  <= p1_valid_d;
            p1_addr_q   <= p1_addr_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_din    = fb_din_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized bench for sprite_blitter: per-cycle comparison against a
// schedule model of CLEAR/SPRITE plus literal expectations per command.
module tb_sprite_blitter;

    localparam int N = 320 * 240;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [3:0]  cmd_sprite = '0;
    logic [3:0]  cmd_color = '0;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [3:0]  fb_din;
    logic        busy;
    logic        done;

    logic [3:0]  rom_mem [4096];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // model state: 0 idle, 1 clear, 2 sprite, 3 just out of reset
    int m_mode = 3;
    int m_T = 0, m_x = 0, m_y = 0, m_spr = 0, m_col = 0, m_idx = 0;
    int acc_n = 0;
    int st_wr[64], st_first[64], st_last[64], st_max[64];
    int st_zero[64], st_doff[64], st_T[64], st_dcyc[64];

    always #10 clk = ~clk;

    sprite_blitter dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_sprite(cmd_sprite), .cmd_color(cmd_color),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
        .busy(busy), .done(done)
    );

    // sync-read sprite ROM and cycle counter
    initial begin
        forever begin
            @(posedge clk);
            rom_data <= rom_mem[rom_addr];
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // compare process
    initial begin
        int off, k, px, py, v;
        int e_we, e_busy, e_done, e_rdy, e_addr, e_din;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_fb_we", fb_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ready", cmd_ready, 0);
                chk("rst_fb_addr", fb_addr, 0);
                chk("rst_fb_din", fb_din, 0);
                chk("rst_rom_addr", rom_addr, 0);
                m_mode = 3;
            end else begin
                e_we = 0; e_busy = 0; e_done = 0; e_rdy = 0;
                e_addr = 0; e_din = 0;
                off = cyc - m_T;
                if (m_mode == 0) begin
                    e_rdy = 1;
                end else if (m_mode == 1) begin
                    e_busy = 1;
                    e_we   = (off >= 1 && off <= N) ? 1 : 0;
                    e_addr = off - 1;
                    e_din  = m_col;
                    e_done = (off == N + 1) ? 1 : 0;
                end else if (m_mode == 2) begin
                    e_busy = 1;
                    k = off - 3;
                    if (k >= 0 && k < 256) begin
                        px = m_x + k % 16;
                        py = m_y + k / 16;
                        v  = int'(rom_mem[m_spr * 256 + k]);
                        e_we   = (px < 320 && py < 240 && v != 0) ? 1 : 0;
                        e_addr = py * 320 + px;
                        e_din  = v;
                    end
                    e_done = (off == 259) ? 1 : 0;
                end
                chk("fb_we", fb_we, e_we);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("cmd_ready", cmd_ready, e_rdy);
                if (e_we != 0) begin
                    chk("fb_addr", fb_addr, e_addr);
                    chk("fb_din", fb_din, e_din);
                end
                if (m_mode == 1 || m_mode == 2) begin
                    if (fb_we) begin
                        st_wr[m_idx]++;
                        if (st_first[m_idx] < 0) st_first[m_idx] = int'(fb_addr);
                        st_last[m_idx] = int'(fb_addr);
                        if (int'(fb_addr) > st_max[m_idx]) st_max[m_idx] = int'(fb_addr);
                        if (fb_din == 4'd0) st_zero[m_idx]++;
                    end
                    if (done) begin
                        st_doff[m_idx] = off;
                        st_dcyc[m_idx] = cyc;
                    end
                    if (e_done != 0) m_mode = 0;
                end else if (m_mode == 3) begin
                    m_mode = 0;
                end else if (cmd_valid && acc_n < 64) begin
                    m_idx = acc_n;
                    acc_n++;
                    m_T = cyc;
                    m_mode = cmd_op ? 1 : 2;
                    m_x = int'(cmd_x);
                    m_y = int'(cmd_y);
                    m_spr = int'(cmd_sprite);
                    m_col = int'(cmd_color);
                    st_wr[m_idx] = 0; st_first[m_idx] = -1;
                    st_last[m_idx] = -1; st_max[m_idx] = -1;
                    st_zero[m_idx] = 0; st_doff[m_idx] = -1;
                    st_T[m_idx] = cyc; st_dcyc[m_idx] = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setcmd(input logic op, input int x, input int y,
                          input int spr, input int col);
        cmd_op = op;
        cmd_x = 9'(x);
        cmd_y = 8'(y);
        cmd_sprite = 4'(spr);
        cmd_color = 4'(col);
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("wait_ready", cmd_ready, 1);
    endtask

    task automatic send(input logic op, input int x, input int y,
                        input int spr, input int col, output int idx);
        wait_ready(3000);
        setcmd(op, x, y, spr, col);
        cmd_valid = 1'b1;
        idx = acc_n;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int max);
        int n = 0;
        while (st_dcyc[idx] < 0 && n < max) begin
            step();
            n++;
        end
        chk("done_seen", (st_dcyc[idx] >= 0) ? 1 : 0, 1);
    endtask

    task automatic fill_sprite(input int spr, input int mode);
        for (int k = 0; k < 256; k++) begin
            if (mode == 0)
                rom_mem[spr * 256 + k] = 4'($urandom_range(1, 15));
            else if (mode == 1)
                rom_mem[spr * 256 + k] = (k % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            else
                rom_mem[spr * 256 + k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
    endtask

    initial begin
        int idx, i, n;
        int b_idx[3];
        for (int s = 0; s < 16; s++) fill_sprite(s, 0);
        b_idx[0] = 0; b_idx[1] = 0; b_idx[2] = 0;

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // back-to-back with cmd_valid held; junk fields while busy
        cmd_valid = 1'b1;
        i = 0;
        n = 0;
        while (i < 3 && n < 90000) begin
            if (cmd_ready) begin
                b_idx[i] = acc_n;
                if (i == 0) setcmd(1'b0, 10, 20, 2, 0);
                else if (i == 1) setcmd(1'b1, 77, 33, 9, 5);
                else setcmd(1'b0, 312, 232, 7, 0);
                i++;
            end else begin
                setcmd(1'($urandom), int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)));
            end
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", i, 3);
        wait_done(b_idx[2], 2000);

        chk("spr_writes", st_wr[b_idx[0]], 256);
        chk("spr_first_addr", st_first[b_idx[0]], 6410);
        chk("spr_last_addr", st_last[b_idx[0]], 11225);
        chk("spr_done_off", st_doff[b_idx[0]], 259);
        chk("clr_writes", st_wr[b_idx[1]], 76800);
        chk("clr_first_addr", st_first[b_idx[1]], 0);
        chk("clr_last_addr", st_last[b_idx[1]], 76799);
        chk("clr_done_off", st_doff[b_idx[1]], 76801);
        chk("clr_zero_din", st_zero[b_idx[1]], 0);
        chk("gap_1", st_T[b_idx[1]] - st_dcyc[b_idx[0]], 1);
        chk("gap_2", st_T[b_idx[2]] - st_dcyc[b_idx[1]], 1);
        chk("clip_writes", st_wr[b_idx[2]], 64);
        chk("clip_max_addr", st_max[b_idx[2]], 76799);
        chk("clip_done_off", st_doff[b_idx[2]], 259);

        // transparency
        fill_sprite(5, 1);
        send(1'b0, 100, 100, 5, 0, idx);
        wait_done(idx, 2000);
        chk("transp_writes", st_wr[idx], 128);
        chk("transp_zero_din", st_zero[idx], 0);

        // random sprites, random placement incl. partial/off-frame
        repeat (8) begin
            int spr;
            spr = int'($urandom_range(0, 15));
            fill_sprite(spr, 2);
            send(1'b0, int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
                 spr, int'($urandom_range(0, 15)), idx);
            wait_done(idx, 2000);
        end

        // fully off-frame and single corner pixel
        send(1'b0, 320, 10, 4, 0, idx);
        wait_done(idx, 2000);
        chk("offx_writes", st_wr[idx], 0);
        chk("offx_done_off", st_doff[idx], 259);
        send(1'b0, 100, 240, 4, 0, idx);
        wait_done(idx, 2000);
        chk("offy_writes", st_wr[idx], 0);
        fill_sprite(6, 0);
        send(1'b0, 319, 239, 6, 0, idx);
        wait_done(idx, 2000);
        chk("corner_writes", st_wr[idx], 1);
        chk("corner_addr", st_max[idx], 76799);

        // reset at DRAW cycle T+100
        fill_sprite(3, 0);
        send(1'b0, 50, 60, 3, 0, idx);
        repeat (99) step();
        rst_n = 1'b0;
        repeat (3) step();
        chk("abort_writes", st_wr[idx], 97);
        rst_n = 1'b1;
        step();

        send(1'b1, 0, 0, 0, 9, idx);
        repeat (300) step();
        chk("reclear_first_addr", st_first[idx], 0);
        chk("reclear_writes", st_wr[idx], 300);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
